// File: rtl/exe_issue_arbiter.sv
// exe_issue_arbiter: per-cycle unit scheduler for the dual-issue pipe.
// Resolves ALU0/ALU1/BEU/LSU structural hazards for an in-order pair, splits
// conflicting pairs over two cycles and tracks LSU occupancy with credits.
// Optional macro EXE_ARB_ALU_RR_EN: round-robin placement of a lone ALU op.
`ifndef H_EXE_UNIT_WIDTH
`define H_EXE_UNIT_WIDTH 4
`endif
`ifndef H_ALU0
`define H_ALU0 0
`endif
`ifndef H_ALU1
`define H_ALU1 1
`endif
`ifndef H_BEU
`define H_BEU 2
`endif
`ifndef H_LSU
`define H_LSU 3
`endif

module exe_issue_arbiter #(
  parameter int unsigned LSU_CREDITS = 2,
  parameter int unsigned CRED_W      = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         inst0_valid_i,
  input  logic [1:0]                   inst0_class_i,
  input  logic                         inst1_valid_i,
  input  logic [1:0]                   inst1_class_i,
  output logic                         pair_ready_o,
  input  logic                         exe_ready_i,
  input  logic                         flush_i,
  input  logic                         lsu_done_i,
  output logic                         iss0_valid_o,
  output logic [`H_EXE_UNIT_WIDTH-1:0] iss0_h_exe_unit_o,
  output logic                         iss1_valid_o,
  output logic [`H_EXE_UNIT_WIDTH-1:0] iss1_h_exe_unit_o,
  output logic [CRED_W-1:0]            lsu_credits_o,
  output logic                         credit_err_o
);

  localparam int unsigned UW = `H_EXE_UNIT_WIDTH;
  localparam logic [1:0] C_ALU = 2'd0;
  localparam logic [1:0] C_BEU = 2'd1;
  localparam logic [1:0] C_LSU = 2'd2;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(LSU_CREDITS);

  typedef enum logic {ST_PAIR = 1'b0, ST_SECOND = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CRED_W-1:0] r_credits;
  logic              r_credit_err;
  logic              r_iss0_valid;
  logic              r_iss1_valid;
  logic [UW-1:0]     r_iss0_unit;
  logic [UW-1:0]     r_iss1_unit;

  logic              w_head_lsu;
  logic              w_stall;
  logic              w_split;
  logic              w_iss0_v;
  logic              w_iss1_v;
  logic              w_alu0;
  logic              w_alu1;
  logic              w_dual_alu;
  logic              w_lsu_issue;
  logic              w_alu_sel;
  logic [UW-1:0]     w_iss0_unit;
  logic [UW-1:0]     w_iss1_unit;

  // Map a unit class to its one-hot execute vector; NONE yields all zeros.
  function automatic logic [UW-1:0] unit_vec(input logic [1:0] cls, input logic alu_hi);
    logic [UW-1:0] v;
    v = '0;
    case (cls)
      C_ALU: begin
        if (alu_hi) v[`H_ALU1] = 1'b1;
        else        v[`H_ALU0] = 1'b1;
      end
      C_BEU:   v[`H_BEU] = 1'b1;
      C_LSU:   v[`H_LSU] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_PAIR;
    else        r_state <= w_state_nxt;
  end

  // Next-state, stall/split decision and pair handshake.
  always_comb begin
    w_state_nxt  = r_state;
    pair_ready_o = 1'b0;
    w_iss0_v     = 1'b0;
    w_iss1_v     = 1'b0;
    w_head_lsu   = (r_state == ST_PAIR) ? (inst0_valid_i && (inst0_class_i == C_LSU))
                                        : (inst1_class_i == C_LSU);
    w_stall      = !exe_ready_i || flush_i || (w_head_lsu && (r_credits == '0));
    w_split      = inst1_valid_i &&
                   (((inst0_class_i == C_BEU) && (inst1_class_i == C_BEU)) ||
                    ((inst0_class_i == C_LSU) && (inst1_class_i == C_LSU)) ||
                    ((inst1_class_i == C_LSU) && (inst0_class_i != C_LSU) && (r_credits == '0)));
    if (!w_stall) begin
      if (r_state == ST_PAIR) begin
        w_iss0_v = inst0_valid_i;
        if (w_split) begin
          w_state_nxt = ST_SECOND;
        end else begin
          w_iss1_v     = inst1_valid_i;
          pair_ready_o = 1'b1;
        end
      end else begin
        w_iss1_v     = 1'b1;
        pair_ready_o = 1'b1;
        w_state_nxt  = ST_PAIR;
      end
    end
    if (flush_i) w_state_nxt = ST_PAIR;
  end

  assign w_alu0      = w_iss0_v && (inst0_class_i == C_ALU);
  assign w_alu1      = w_iss1_v && (inst1_class_i == C_ALU);
  assign w_dual_alu  = w_alu0 && w_alu1;
  assign w_lsu_issue = (w_iss0_v && (inst0_class_i == C_LSU)) ||
                       (w_iss1_v && (inst1_class_i == C_LSU));
  assign w_iss0_unit = unit_vec(inst0_class_i, w_dual_alu ? 1'b0 : w_alu_sel);
  assign w_iss1_unit = unit_vec(inst1_class_i, w_dual_alu ? 1'b1 : w_alu_sel);

`ifdef EXE_ARB_ALU_RR_EN
  logic r_alu_ptr;
  logic w_lone_alu;

  assign w_lone_alu = w_alu0 ^ w_alu1;
  assign w_alu_sel  = r_alu_ptr;

  // Alternate a lone ALU op between ALU0 and ALU1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_alu_ptr <= 1'b0;
    else if (w_lone_alu) r_alu_ptr <= ~r_alu_ptr;
  end
`else
  assign w_alu_sel = 1'b0;
`endif

  // Registered issue vectors, valid for exactly one cycle per decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss0_valid <= 1'b0;
      r_iss1_valid <= 1'b0;
      r_iss0_unit  <= '0;
      r_iss1_unit  <= '0;
    end else begin
      r_iss0_valid <= w_iss0_v;
      r_iss1_valid <= w_iss1_v;
      r_iss0_unit  <= w_iss0_v ? w_iss0_unit : '0;
      r_iss1_unit  <= w_iss1_v ? w_iss1_unit : '0;
    end
  end

  // LSU credit counter; a completion with no op in flight saturates and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits    <= CRED_MAX;
      r_credit_err <= 1'b0;
    end else begin
      if (w_lsu_issue && !lsu_done_i)
        r_credits <= r_credits - CRED_W'(1);
      else if (lsu_done_i && !w_lsu_issue && (r_credits != CRED_MAX))
        r_credits <= r_credits + CRED_W'(1);
      if (lsu_done_i && (r_credits == CRED_MAX))
        r_credit_err <= 1'b1;
    end
  end

  assign iss0_valid_o      = r_iss0_valid;
  assign iss1_valid_o      = r_iss1_valid;
  assign iss0_h_exe_unit_o = r_iss0_unit;
  assign iss1_h_exe_unit_o = r_iss1_unit;
  assign lsu_credits_o     = r_credits;
  assign credit_err_o      = r_credit_err;

endmodule

// File: tb/tb_exe_issue_arbiter.sv
// Self-checking bench for exe_issue_arbiter: directed scenarios with literal
// expectations plus a randomized run, all compared against a pair-level model.
`ifndef H_EXE_UNIT_WIDTH
`define H_EXE_UNIT_WIDTH 4
`endif
`ifndef H_ALU0
`define H_ALU0 0
`endif
`ifndef H_ALU1
`define H_ALU1 1
`endif
`ifndef H_BEU
`define H_BEU 2
`endif
`ifndef H_LSU
`define H_LSU 3
`endif

module tb_exe_issue_arbiter;

  localparam int UW   = `H_EXE_UNIT_WIDTH;
  localparam int MAXC = 2;
  localparam int ALU = 0, BEU = 1, LSU = 2, NONE = 3;
  localparam logic [3:0] L_ALU0 = 4'b0001, L_ALU1 = 4'b0010, L_BEU = 4'b0100, L_LSU = 4'b1000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inst0_valid_i, inst1_valid_i;
  logic [1:0]    inst0_class_i, inst1_class_i;
  logic          pair_ready_o;
  logic          exe_ready_i, flush_i, lsu_done_i;
  logic          iss0_valid_o, iss1_valid_o;
  logic [UW-1:0] iss0_h_exe_unit_o, iss1_h_exe_unit_o;
  logic [2:0]    lsu_credits_o;
  logic          credit_err_o;

  exe_issue_arbiter #(.LSU_CREDITS(MAXC), .CRED_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst0_valid_i(inst0_valid_i), .inst0_class_i(inst0_class_i),
    .inst1_valid_i(inst1_valid_i), .inst1_class_i(inst1_class_i),
    .pair_ready_o(pair_ready_o), .exe_ready_i(exe_ready_i),
    .flush_i(flush_i), .lsu_done_i(lsu_done_i),
    .iss0_valid_o(iss0_valid_o), .iss0_h_exe_unit_o(iss0_h_exe_unit_o),
    .iss1_valid_o(iss1_valid_o), .iss1_h_exe_unit_o(iss1_h_exe_unit_o),
    .lsu_credits_o(lsu_credits_o), .credit_err_o(credit_err_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: credits left, sticky error, RR pointer, "older half already gone".
  int m_cred;
  bit m_err, m_ptr, m_half;
  // Model decision for the current cycle.
  bit            d_pr, d_v0, d_v1, d_err, d_ptr, d_half;
  logic [UW-1:0] d_u0, d_u1;
  int            d_cred;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [UW-1:0] uvec(input int cls, input bit hi);
    logic [UW-1:0] one;
    one = UW'(1);
    case (cls)
      ALU:     return hi ? (one << `H_ALU1) : (one << `H_ALU0);
      BEU:     return one << `H_BEU;
      LSU:     return one << `H_LSU;
      default: return '0;
    endcase
  endfunction

  // Decide this cycle's outcome from the pair still owed to execute.
  task automatic model_decide();
    int cls[2];
    int slot[2];
    int n, nalu, nlsu, a;
    bit hi;
    d_pr = 0; d_v0 = 0; d_v1 = 0; d_u0 = '0; d_u1 = '0;
    d_half = m_half; d_ptr = m_ptr;
    n = 0; nalu = 0; nlsu = 0;
    if (m_half) begin
      cls[0] = int'(inst1_class_i); slot[0] = 1; n = 1;
    end else begin
      if (inst0_valid_i) begin cls[n] = int'(inst0_class_i); slot[n] = 0; n++; end
      if (inst1_valid_i) begin cls[n] = int'(inst1_class_i); slot[n] = 1; n++; end
    end
    if (exe_ready_i && !flush_i && !(n > 0 && cls[0] == LSU && m_cred == 0)) begin
      if (n == 2 && ((cls[0] == cls[1] && (cls[0] == BEU || cls[0] == LSU)) ||
                     (cls[1] == LSU && m_cred == 0))) begin
        n = 1; d_half = 1;
      end else begin
        d_pr = 1; d_half = 0;
      end
      for (int i = 0; i < n; i++) begin
        if (cls[i] == ALU) nalu++;
        if (cls[i] == LSU) nlsu++;
      end
      a = 0;
      for (int i = 0; i < n; i++) begin
        if (nalu == 2) hi = (a == 1);
`ifdef EXE_ARB_ALU_RR_EN
        else hi = m_ptr;
`else
        else hi = 0;
`endif
        if (cls[i] == ALU) a++;
        if (slot[i] == 0) begin d_v0 = 1; d_u0 = uvec(cls[i], hi); end
        else              begin d_v1 = 1; d_u1 = uvec(cls[i], hi); end
      end
`ifdef EXE_ARB_ALU_RR_EN
      if (nalu == 1) d_ptr = ~m_ptr;
`endif
    end
    if (flush_i) d_half = 0;
    d_err  = m_err | (lsu_done_i && m_cred == MAXC);
    d_cred = m_cred - nlsu + (lsu_done_i ? 1 : 0);
    if (d_cred > MAXC) d_cred = MAXC;
  endtask

  // One clock: drive inputs, check the handshake, then the registered outputs.
  task automatic cycle(input bit v0, input int c0, input bit v1, input int c1,
                       input bit rdy, input bit fl, input bit dn);
    inst0_valid_i = v0; inst0_class_i = 2'(c0);
    inst1_valid_i = v1; inst1_class_i = 2'(c1);
    exe_ready_i = rdy; flush_i = fl; lsu_done_i = dn;
    #1;
    model_decide();
    chk("pair_ready", 32'(pair_ready_o), 32'(d_pr));
    @(posedge clk); #1;
    chk("iss0_valid", 32'(iss0_valid_o), 32'(d_v0));
    chk("iss0_unit",  32'(iss0_h_exe_unit_o), 32'(d_u0));
    chk("iss1_valid", 32'(iss1_valid_o), 32'(d_v1));
    chk("iss1_unit",  32'(iss1_h_exe_unit_o), 32'(d_u1));
    chk("credits",    32'(lsu_credits_o), 32'(d_cred));
    chk("credit_err", 32'(credit_err_o), 32'(d_err));
    m_cred = d_cred; m_err = d_err; m_ptr = d_ptr; m_half = d_half;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    inst0_valid_i = 0; inst1_valid_i = 0; inst0_class_i = 0; inst1_class_i = 0;
    exe_ready_i = 0; flush_i = 0; lsu_done_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_iss0_valid", 32'(iss0_valid_o), 32'd0);
    chk("rst_iss1_valid", 32'(iss1_valid_o), 32'd0);
    chk("rst_credits", 32'(lsu_credits_o), 32'd2);
    chk("rst_err", 32'(credit_err_o), 32'd0);
    chk("rst_pair_ready", 32'(pair_ready_o), 32'd0);
    rst_n = 1'b1;
    m_cred = MAXC; m_err = 0; m_ptr = 0; m_half = 0;
    @(posedge clk); #1;
  endtask

  bit            pv0, pv1, rdy, fl, dn;
  int            pc0, pc1;
  logic [3:0]    rr_exp[4];

  initial begin
    do_reset();

    // ALU+ALU: dual issue on ALU0/ALU1.
    cycle(1, ALU, 1, ALU, 1, 0, 0);
    chk("aa_u0", 32'(iss0_h_exe_unit_o), 32'(L_ALU0));
    chk("aa_u1", 32'(iss1_h_exe_unit_o), 32'(L_ALU1));

    // BEU+BEU: split across two cycles.
    cycle(1, BEU, 1, BEU, 1, 0, 0);
    chk("bb1_v1", 32'(iss1_valid_o), 32'd0);
    chk("bb1_u0", 32'(iss0_h_exe_unit_o), 32'(L_BEU));
    cycle(1, BEU, 1, BEU, 1, 0, 0);
    chk("bb2_v0", 32'(iss0_valid_o), 32'd0);
    chk("bb2_u1", 32'(iss1_h_exe_unit_o), 32'(L_BEU));

    // Three LSU heads with two credits: third stalls until a done returns.
    cycle(1, LSU, 0, NONE, 1, 0, 0);
    cycle(1, LSU, 0, NONE, 1, 0, 0);
    chk("lsu2_cred", 32'(lsu_credits_o), 32'd0);
    cycle(1, LSU, 0, NONE, 1, 0, 0);
    chk("lsu3_stall", 32'(iss0_valid_o), 32'd0);
    cycle(1, LSU, 0, NONE, 1, 0, 1);
    chk("lsu3_done_cred", 32'(lsu_credits_o), 32'd1);
    cycle(1, LSU, 0, NONE, 1, 0, 0);
    chk("lsu3_issue", 32'(iss0_h_exe_unit_o), 32'(L_LSU));
    chk("lsu3_cred0", 32'(lsu_credits_o), 32'd0);

    // ALU+LSU at zero credits: ALU goes, LSU waits for a done.
    cycle(1, ALU, 1, LSU, 1, 0, 0);
    chk("al_u0", 32'(iss0_h_exe_unit_o), 32'(L_ALU0));
    cycle(1, ALU, 1, LSU, 1, 0, 0);
    chk("al_stall", 32'(iss1_valid_o), 32'd0);
    cycle(1, ALU, 1, LSU, 1, 0, 1);
    cycle(1, ALU, 1, LSU, 1, 0, 0);
    chk("al_u1", 32'(iss1_h_exe_unit_o), 32'(L_LSU));

    // Return all credits, then flush while the younger half is pending.
    cycle(0, NONE, 0, NONE, 0, 0, 1);
    cycle(0, NONE, 0, NONE, 0, 0, 1);
    cycle(1, BEU, 1, BEU, 1, 0, 0);
    cycle(1, BEU, 1, BEU, 1, 1, 0);
    chk("fl_v1", 32'(iss1_valid_o), 32'd0);
    chk("fl_cred", 32'(lsu_credits_o), 32'd2);
    cycle(1, ALU, 1, ALU, 1, 0, 0);
    chk("fl_pair_v0", 32'(iss0_valid_o), 32'd1);

    // Completion with nothing in flight.
    cycle(0, NONE, 0, NONE, 0, 0, 1);
    chk("err_set", 32'(credit_err_o), 32'd1);
    chk("err_cred", 32'(lsu_credits_o), 32'd2);

    // Reset from the SECOND state, then four lone ALU ops.
    cycle(1, BEU, 1, BEU, 1, 0, 0);
    do_reset();
`ifdef EXE_ARB_ALU_RR_EN
    rr_exp = '{L_ALU0, L_ALU1, L_ALU0, L_ALU1};
`else
    rr_exp = '{L_ALU0, L_ALU0, L_ALU0, L_ALU0};
`endif
    for (int i = 0; i < 4; i++) begin
      cycle(1, ALU, 0, NONE, 1, 0, 0);
      chk("lone_alu", 32'(iss0_h_exe_unit_o), 32'(rr_exp[i]));
    end

    // Randomized traffic; upstream holds a pair until it is consumed.
    pv0 = 1; pc0 = ALU; pv1 = 0; pc1 = NONE;
    for (int k = 0; k < 3000; k++) begin
      rdy = ($urandom % 5) != 0;
      fl  = ($urandom % 40) == 0;
      dn  = (m_cred < MAXC) && (($urandom % 3) == 0);
      cycle(pv0, pc0, pv1, pc1, rdy, fl, dn);
      if (d_pr || fl) begin
        pv0 = ($urandom % 10) != 0;
        pc0 = int'($urandom % 4);
        pv1 = pv0 && (($urandom % 10) < 7);
        pc1 = int'($urandom % 4);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exe_issue_arbiter.md
Name: exe_issue_arbiter

Overview:
- Per-cycle unit scheduler ahead of the operand/execute sequencer in the dual-issue pipe.
- Takes the decoded unit class of an in-order pair (inst0 older), resolves structural hazards on ALU0/ALU1/BEU/LSU, and tracks LSU occupancy with credits.
- Emits registered one-hot `H_EXE_UNIT_WIDTH vectors per slot; splits conflicting pairs over two cycles.

Parameters:
- LSU_CREDITS, 2, max LSU ops in flight (1..7).
- CRED_W, 3, credit counter width; must hold LSU_CREDITS.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- inst0_valid_i  in  1  older instruction valid
- inst0_class_i  in  2  0=ALU 1=BEU 2=LSU 3=NONE
- inst1_valid_i  in  1  younger instruction valid; only legal with inst0_valid_i=1
- inst1_class_i  in  2  same encoding
- pair_ready_o  out  1  pair consumed this cycle; upstream holds inputs while 0
- exe_ready_i  in  1  downstream accepts an issue this cycle
- flush_i  in  1  synchronous pipeline flush
- lsu_done_i  in  1  one LSU op completed; returns one credit
- iss0_valid_o  out  1  slot0 issued (registered)
- iss0_h_exe_unit_o  out  `H_EXE_UNIT_WIDTH  slot0 one-hot unit, bits `H_ALU0/`H_ALU1/`H_BEU/`H_LSU
- iss1_valid_o  out  1  slot1 issued (registered)
- iss1_h_exe_unit_o  out  `H_EXE_UNIT_WIDTH  slot1 one-hot unit
- lsu_credits_o  out  CRED_W  current credits
- credit_err_o  out  1  sticky: lsu_done_i at full credits

Behaviour:
- Reset: all iss* outputs 0, state PAIR, credits=LSU_CREDITS, alu_ptr=0, credit_err_o=0; pair_ready_o combinational, 0 while exe_ready_i=0.
- States: PAIR (fresh pair at inputs), SECOND (inst0 already issued, inst1 pending; inputs held).
- Head = inst0 in PAIR, inst1 in SECOND. Stall (nothing issues, pair_ready_o=0, state kept) when exe_ready_i=0, flush_i=1, or head is LSU with credits=0.
- PAIR, split when inst1 valid and: both BEU; both LSU; or inst1 LSU, inst0 non-LSU, credits=0. On split: issue inst0 on slot0 only, pair_ready_o=0, go SECOND.
- PAIR, no split: issue inst0 slot0, inst1 slot1 (if valid), pair_ready_o=1.
- SECOND, no stall: issue inst1 on slot1, iss0_valid_o=0, pair_ready_o=1, go PAIR.
- Unit mapping: BEU->`H_BEU, LSU->`H_LSU, NONE->all-zero vector (valid still 1). Two ALUs issued together: slot0 `H_ALU0, slot1 `H_ALU1. Lone ALU: `H_ALU0 (see optional feature).
- Latency: decision cycle N -> iss* outputs valid cycle N+1 for exactly one cycle; iss*_valid_o cleared any cycle with no issue.
- Credits: -1 per LSU issued; +1 per lsu_done_i; both same cycle -> unchanged. Decision uses registered count (no same-cycle done bypass). Done at LSU_CREDITS: count saturates, credit_err_o set until reset.
- Flush: next cycle state=PAIR, iss* valid 0; credits and alu_ptr untouched (in-flight LSU still returns done). Flush overrides issue in same cycle.
- Reset mid-SECOND: returns PAIR; upstream is reset too.

Optional Feature:
- EXE_ARB_ALU_RR_EN defined: lone ALU instruction (single-ALU pair or SECOND) goes to `H_ALU1 if alu_ptr=1 else `H_ALU0; alu_ptr toggles on every lone-ALU issue; dual-ALU issue unchanged, ptr kept.
- Undefined: lone ALU always `H_ALU0; no alu_ptr flop.

Test Plan:
- ALU+ALU pair, exe_ready_i=1 -> next cycle iss0=`H_ALU0, iss1=`H_ALU1, both valid, pair_ready_o=1 same cycle.
- BEU+BEU pair -> cycle1 slot0 BEU only, pair_ready_o=0; cycle2 slot1 BEU, pair_ready_o=1; state back PAIR.
- LSU_CREDITS=2, three LSU-head pairs, no done -> two issue, third stalls with credits=0; one lsu_done_i -> issues next cycle, credits ends 0.
- ALU+LSU with credits=0 -> ALU slot0 issued, split; SECOND stalls until lsu_done_i, then slot1 `H_LSU.
- flush_i during SECOND -> no issue next cycle, state PAIR, credits unchanged; lsu_done_i at credits=2 -> credit_err_o=1, credits stay 2.
- EXE_ARB_ALU_RR_EN: four single-ALU pairs -> ALU0, ALU1, ALU0, ALU1; without macro all ALU0.
